ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the fetch address loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 2, the maximum number of in-flight plus buffered instructions (credit limit), 1..4.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port imem_req_addr  output  32  byte address of request, word aligned.
REQ-008 SHALL have port imem_rsp_valid  input  1  instruction word returned; responses arrive in request order, at least 1 cycle after acceptance.
REQ-009 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  single-cycle pipeline redirect (branch/jump).
REQ-011 SHALL have port redirect_pc  input  32  new fetch address.
REQ-012 SHALL have port inst_valid  output  1  buffered instruction available to decode.
REQ-013 SHALL have port inst_ready  input  1  decode consumes instruction.
REQ-014 SHALL have port inst_o  output  32  instruction word at buffer head.
REQ-015 SHALL have port inst_pc_o  output  32  fetch address of inst_o.

Function
REQ-016 SHALL hold a fetch PC; imem_req_addr SHALL equal fetch PC, and a request is accepted on a cycle with imem_req_valid and imem_req_ready both high.
REQ-017 SHALL advance fetch PC by 4 (mod 2^32, wrap from 32'hFFFFFFFC to 0) on each accepted request, and SHALL hold it otherwise.
REQ-018 SHALL assert imem_req_valid only when reset is low, redirect_valid is low, and (outstanding + buffered) < DEPTH.
REQ-019 SHALL keep imem_req_valid and imem_req_addr stable while imem_req_valid is high and imem_req_ready is low, unless redirect_valid is high.
REQ-020 SHALL record each accepted address in an in-order address queue of DEPTH entries and pair it with the next response.
REQ-021 SHALL write each non-discarded response {addr, data} into a DEPTH-entry FIFO; inst_valid SHALL rise no earlier than the cycle after imem_rsp_valid (no combinational bypass).
REQ-022 SHALL drive inst_valid = FIFO non-empty, inst_o/inst_pc_o = FIFO head, and pop on inst_valid and inst_ready.
REQ-023 SHALL never overflow: the credit rule of REQ-018 guarantees a free FIFO slot for every outstanding response; a simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-024 SHALL, on redirect_valid, load fetch PC with {redirect_pc[31:2], 2'b00}, flush the FIFO, and mark all currently outstanding requests as discard.
REQ-025 SHALL silently drop discarded responses (no FIFO write, no inst_valid) and decrement the discard count and outstanding count for each.
REQ-026 SHALL give redirect priority over a same-cycle request acceptance, response, or pop: no request is accepted that cycle, and a response arriving that cycle is discarded.
REQ-027 SHALL treat back-to-back redirects as cumulative: the last redirect_pc wins, and all older in-flight responses stay discarded.
REQ-028 SHALL resume requesting the cycle after a redirect if credit allows; the first post-redirect request address SHALL be the aligned redirect_pc.
REQ-029 SHALL ignore imem_rsp_valid when outstanding is zero and SHALL flag it via a simulation-only assertion.

Reset
REQ-030 SHALL, while reset is high, set fetch PC = RESET_PC, imem_req_valid = 0, inst_valid = 0, inst_o = 0, inst_pc_o = 0, and clear the FIFO, address queue, outstanding count and discard count.
REQ-031 SHALL discard, and never deliver, any response to a request issued before a reset that occurs mid-operation.
REQ-032 SHALL assert imem_req_valid with imem_req_addr = RESET_PC on the first cycle after reset deasserts.

Verification
REQ-033 Reset then ready=1, 1-cycle memory, inst_ready=1 -> addresses 0,4,8,... issued, inst_pc_o 0,4,8 in order, with data matching the memory words.
REQ-034 inst_ready=0 with DEPTH=2 -> exactly 2 requests accepted, then imem_req_valid=0; one pop -> one new request issues.
REQ-035 imem_req_ready low for 3 cycles -> imem_req_addr held at 32'h8, and the PC does not advance.
REQ-036 Redirect to 32'h103 with 2 outstanding -> both responses dropped, FIFO empty, next request address 32'h100, and next inst_pc_o = 32'h100.
REQ-037 Redirect in the same cycle as a response and pop -> response discarded, no request accepted, and the PC equals the redirect target.
REQ-038 PC at 32'hFFFFFFFC accepted -> next request address 32'h00000000.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: credit-limited in-order fetch with an address queue,
// a delivery FIFO towards decode, and redirect-driven discard of in-flight responses.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  // Storage is sized for the largest legal DEPTH; pointers wrap at DEPTH-1.
  localparam int unsigned SLOTS = 4;

  logic [31:0] pc_q, pc_d;

  logic [31:0] aq_addr_q [SLOTS];
  logic [1:0]  aq_wr_q, aq_wr_d;
  logic [1:0]  aq_rd_q, aq_rd_d;
  logic [2:0]  out_q, out_d;
  logic [2:0]  disc_q, disc_d;

  logic [31:0] fifo_addr_q [SLOTS];
  logic [31:0] fifo_data_q [SLOTS];
  logic [1:0]  f_wr_q, f_wr_d;
  logic [1:0]  f_rd_q, f_rd_d;
  logic [2:0]  cnt_q, cnt_d;

  logic [3:0]  inflight;
  logic        credit_ok;
  logic        accept;
  logic        rsp_take;
  logic        rsp_keep;
  logic        pop;
  logic        head_valid;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign inflight   = {1'b0, out_q} + {1'b0, cnt_q};
  assign credit_ok  = inflight < 4'(DEPTH);
  assign head_valid = cnt_q != 3'd0;

  assign imem_req_valid = !reset && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;

  assign accept   = imem_req_valid && imem_req_ready;
  assign rsp_take = imem_rsp_valid && (out_q != 3'd0);
  assign rsp_keep = rsp_take && (disc_q == 3'd0) && !redirect_valid;
  assign pop      = head_valid && inst_ready && !redirect_valid;

  assign inst_valid = head_valid && !reset;
  assign inst_o     = inst_valid ? fifo_data_q[f_rd_q] : '0;
  assign inst_pc_o  = inst_valid ? fifo_addr_q[f_rd_q] : '0;

  always_comb begin
    pc_d    = pc_q;
    aq_wr_d = aq_wr_q;
    aq_rd_d = aq_rd_q;
    out_d   = out_q;
    disc_d  = disc_q;
    f_wr_d  = f_wr_q;
    f_rd_d  = f_rd_q;
    cnt_d   = cnt_q;

    if (accept) begin
      pc_d    = pc_q + 32'd4;
      aq_wr_d = ptr_inc(aq_wr_q);
    end
    if (rsp_take) begin
      aq_rd_d = ptr_inc(aq_rd_q);
    end
    out_d = out_q + {2'b00, accept} - {2'b00, rsp_take};

    if (redirect_valid) begin
      // Everything still outstanding after this cycle's response becomes discard.
      pc_d   = redirect_pc & 32'hFFFF_FFFC;
      disc_d = out_q - {2'b00, rsp_take};
      f_wr_d = '0;
      f_rd_d = '0;
      cnt_d  = '0;
    end else begin
      if (rsp_take && (disc_q != 3'd0)) begin
        disc_d = disc_q - 3'd1;
      end
      if (rsp_keep) begin
        f_wr_d = ptr_inc(f_wr_q);
      end
      if (pop) begin
        f_rd_d = ptr_inc(f_rd_q);
      end
      cnt_d = cnt_q + {2'b00, rsp_keep} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      aq_wr_q <= '0;
      aq_rd_q <= '0;
      out_q   <= '0;
      disc_q  <= '0;
      f_wr_q  <= '0;
      f_rd_q  <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        aq_addr_q[i]   <= '0;
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      aq_wr_q <= aq_wr_d;
      aq_rd_q <= aq_rd_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      f_wr_q  <= f_wr_d;
      f_rd_q  <= f_rd_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        aq_addr_q[aq_wr_q] <= pc_q;
      end
      if (rsp_keep) begin
        fifo_addr_q[f_wr_q] <= aq_addr_q[aq_rd_q];
        fifo_data_q[f_wr_q] <= imem_rsp_data;
      end
    end
  end

  // A response with nothing outstanding is a memory-side protocol error.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
    !(imem_rsp_valid && (out_q == 3'd0)));

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a per-cycle vector table for streaming fetch,
// then hand-written sequences for back-pressure, stalls, redirects, wrap and reset.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_acc = 0;
  int          acc0;
  logic        mem_en;
  logic [31:0] mq [$];

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        irdy;
    logic        exp_v;
    logic [31:0] exp_a;
    logic        exp_iv;
    logic [31:0] exp_ipc;
  } vec_t;

  vec_t vt [11];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Mid-cycle: record accepted requests and check delivered data against memory.
  task automatic to_mid();
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      mq.push_back(imem_req_addr);
      n_acc++;
    end
    if (inst_valid) chk("data", inst_o, memw(inst_pc_o));
  endtask

  // Just after the edge: the memory answers one cycle after acceptance.
  task automatic to_next();
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      imem_rsp_valid = 1'b0;
    end else if (mem_en && mq.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memw(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
    end
  endtask

  task automatic cycle();
    to_mid();
    to_next();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic wait_inst(input string nm, input logic [31:0] exp);
    bit got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      to_mid();
      if (inst_valid) begin
        got = 1'b1;
        chk(nm, inst_pc_o, exp);
      end
      to_next();
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no instruction within budget, expected pc %h", nm, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    mem_en         = 1'b1;

    // Streaming with 1-cycle memory and DEPTH=2: steady state issues 2 of every 3 cycles.
    vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
    vt[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h10};

    for (int i = 0; i < 11; i++) begin
      reset          = vt[i].rst;
      imem_req_ready = vt[i].rdy;
      inst_ready     = vt[i].irdy;
      to_mid();
      chk($sformatf("vec%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, vt[i].exp_v});
      chk($sformatf("vec%0d req_addr", i), imem_req_addr, vt[i].exp_a);
      chk($sformatf("vec%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, vt[i].exp_iv});
      if (vt[i].exp_iv) chk($sformatf("vec%0d inst_pc", i), inst_pc_o, vt[i].exp_ipc);
      if (vt[i].rst) begin
        chk($sformatf("vec%0d rst inst_o", i), inst_o, 32'h0);
        chk($sformatf("vec%0d rst inst_pc", i), inst_pc_o, 32'h0);
      end
      to_next();
    end

    // Decode stalled: credit limit of 2, then one pop frees one request.
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    do_reset();
    acc0 = n_acc;
    for (int i = 0; i < 5; i++) cycle();
    to_mid();
    chk("stall accepted", n_acc - acc0, 2);
    chk("stall req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("stall head pc", inst_pc_o, 32'h0);
    to_next();
    inst_ready = 1'b1;
    to_mid();
    chk("pop cycle req_valid", {31'b0, imem_req_valid}, 32'd0);
    to_next();
    inst_ready = 1'b0;
    to_mid();
    chk("after pop req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("after pop req_addr", imem_req_addr, 32'h8);
    to_next();
    for (int i = 0; i < 3; i++) cycle();
    to_mid();
    chk("after pop accepted", n_acc - acc0, 3);
    chk("refill req_valid", {31'b0, imem_req_valid}, 32'd0);
    to_next();

    // Memory not ready for 3 cycles while the request for 8 is pending.
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) cycle();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_mid();
      chk($sformatf("hold%0d req_valid", i), {31'b0, imem_req_valid}, 32'd1);
      chk($sformatf("hold%0d req_addr", i), imem_req_addr, 32'h8);
      to_next();
    end
    imem_req_ready = 1'b1;
    to_mid();
    chk("hold release addr", imem_req_addr, 32'h8);
    to_next();
    to_mid();
    chk("hold advance addr", imem_req_addr, 32'hC);
    to_next();

    // Redirect to 0x103 with two requests outstanding and responses held back.
    mem_en = 1'b0;
    do_reset();
    cycle();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    to_mid();
    chk("redir req_valid", {31'b0, imem_req_valid}, 32'd0);
    to_next();
    redirect_valid = 1'b0;
    mem_en         = 1'b1;
    to_mid();
    chk("redir fifo empty", {31'b0, inst_valid}, 32'd0);
    chk("redir req_addr", imem_req_addr, 32'h100);
    chk("redir credit held", {31'b0, imem_req_valid}, 32'd0);
    to_next();
    wait_inst("redir first pc", 32'h100);
    wait_inst("redir second pc", 32'h104);

    // Redirect coinciding with a response and a pop.
    do_reset();
    cycle();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    to_mid();
    chk("coinc head pc", inst_pc_o, 32'h0);
    chk("coinc req_valid", {31'b0, imem_req_valid}, 32'd0);
    to_next();
    redirect_valid = 1'b0;
    to_mid();
    chk("coinc inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("coinc req_valid next", {31'b0, imem_req_valid}, 32'd1);
    chk("coinc req_addr", imem_req_addr, 32'h200);
    to_next();
    wait_inst("coinc first pc", 32'h200);

    // Back-to-back redirects, the last one landing on the wrap boundary.
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    to_mid();
    chk("b2b first req_valid", {31'b0, imem_req_valid}, 32'd0);
    to_next();
    redirect_pc = 32'hFFFF_FFFE;
    to_mid();
    chk("b2b second req_valid", {31'b0, imem_req_valid}, 32'd0);
    to_next();
    redirect_valid = 1'b0;
    to_mid();
    chk("wrap req_addr top", imem_req_addr, 32'hFFFF_FFFC);
    to_next();
    to_mid();
    chk("wrap req_addr zero", imem_req_addr, 32'h0000_0000);
    to_next();
    wait_inst("wrap first pc", 32'hFFFF_FFFC);
    wait_inst("wrap second pc", 32'h0000_0000);

    // Reset in the middle of traffic, then restart at RESET_PC.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h480;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    to_mid();
    chk("midrst req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("midrst inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("midrst inst_o", inst_o, 32'h0);
    chk("midrst inst_pc", inst_pc_o, 32'h0);
    to_next();
    reset = 1'b0;
    to_mid();
    chk("postrst req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("postrst req_addr", imem_req_addr, 32'h0);
    to_next();
    wait_inst("postrst first pc", 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
